// File: rtl/id_ex_stage_if.sv
// ID->EX pipeline bus: decoded fields flowing out of ID and the registered
// copies presented to EX.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic [3:0]      id_alu_op;
  logic [4:0]      id_rs1_id;
  logic [4:0]      id_rs2_id;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [4:0]      id_rd_id;
  logic            id_rd_wr_en;
  logic            id_is_load;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [3:0]      ex_alu_op;
  logic [4:0]      ex_rd_id;
  logic            ex_rd_wr_en;
  logic            ex_is_load;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;

  modport master (
    output id_valid, id_pc, id_imm, id_alu_op, id_rs1_id, id_rs2_id,
           id_use_rs1, id_use_rs2, id_rd_id, id_rd_wr_en, id_is_load,
    input  ex_valid, ex_pc, ex_imm, ex_alu_op, ex_rd_id, ex_rd_wr_en,
           ex_is_load, ex_rs1_val, ex_rs2_val
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_alu_op, id_rs1_id, id_rs2_id,
           id_use_rs1, id_use_rs2, id_rd_id, id_rd_wr_en, id_is_load,
    output ex_valid, ex_pc, ex_imm, ex_alu_op, ex_rd_id, ex_rd_wr_en,
           ex_is_load, ex_rs1_val, ex_rs2_val
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register of the RV32I core: operand bypass at capture,
// load-use bubble insertion, branch flush and downstream hold.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  id_ex_stage_if.slave      pipe,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              mem_wr_en,
  input  logic [4:0]        mem_wr_id,
  input  logic [XLEN-1:0]   mem_wr_data,
  input  logic              flush,
  input  logic              hold,
  output logic              id_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [4:0]      rd_id;
    logic            rd_wr_en;
    logic            is_load;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
  } ex_reg_t;

  ex_reg_t           ex_q, ex_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              ex_fwd_en;
  logic              load_use;
  logic [XLEN-1:0]   rs1_sel, rs2_sel;

  // A load's result is not ready in EX, and a bubble must never forward.
  assign ex_fwd_en = ex_q.valid & ex_q.rd_wr_en & ~ex_q.is_load;

  function automatic logic [XLEN-1:0] sel_operand(
    input logic [4:0]      s_id,
    input logic [XLEN-1:0] rf_data,
    input logic            ex_en,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            mem_en,
    input logic [4:0]      mem_rd,
    input logic [XLEN-1:0] mem_data
  );
    if (s_id == 5'd0)                  return '0;
    else if (ex_en && ex_rd == s_id)   return ex_data;
    else if (mem_en && mem_rd == s_id) return mem_data;
    else                               return rf_data;
  endfunction

  assign rs1_sel = sel_operand(pipe.id_rs1_id, rs1_data, ex_fwd_en, ex_q.rd_id,
                               ex_result, mem_wr_en, mem_wr_id, mem_wr_data);
  assign rs2_sel = sel_operand(pipe.id_rs2_id, rs2_data, ex_fwd_en, ex_q.rd_id,
                               ex_result, mem_wr_en, mem_wr_id, mem_wr_data);

  assign load_use = pipe.id_valid & ex_q.valid & ex_q.is_load & (ex_q.rd_id != 5'd0) &
                    ((pipe.id_use_rs1 & (pipe.id_rs1_id == ex_q.rd_id)) |
                     (pipe.id_use_rs2 & (pipe.id_rs2_id == ex_q.rd_id)));

  assign id_stall = hold | (load_use & ~flush);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (hold) begin
      ex_d = ex_q;
    end else if (flush || load_use) begin
      ex_d.valid    = 1'b0;
      ex_d.rd_wr_en = 1'b0;
      ex_d.is_load  = 1'b0;
      if (!flush && bubble_cnt_q != {CNT_W{1'b1}})
        bubble_cnt_d = bubble_cnt_q + 1'b1;
    end else begin
      ex_d.valid    = pipe.id_valid;
      ex_d.pc       = pipe.id_pc;
      ex_d.imm      = pipe.id_imm;
      ex_d.alu_op   = pipe.id_alu_op;
      ex_d.rd_id    = pipe.id_rd_id;
      ex_d.rd_wr_en = pipe.id_valid & pipe.id_rd_wr_en;
      ex_d.is_load  = pipe.id_valid & pipe.id_is_load;
      ex_d.rs1_val  = rs1_sel;
      ex_d.rs2_val  = rs2_sel;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!n_rst) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign pipe.ex_valid    = ex_q.valid;
  assign pipe.ex_pc       = ex_q.pc;
  assign pipe.ex_imm      = ex_q.imm;
  assign pipe.ex_alu_op   = ex_q.alu_op;
  assign pipe.ex_rd_id    = ex_q.rd_id;
  assign pipe.ex_rd_wr_en = ex_q.rd_wr_en;
  assign pipe.ex_is_load  = ex_q.is_load;
  assign pipe.ex_rs1_val  = ex_q.rs1_val;
  assign pipe.ex_rs2_val  = ex_q.rs2_val;
  assign bubble_cnt       = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, bypass priority, load-use, flush,
// hold, counter saturation and reset during a stall.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] rs1_data, rs2_data, ex_result, mem_wr_data;
  logic        mem_wr_en, flush, hold;
  logic [4:0]  mem_wr_id;
  logic        id_stall, sat_stall;
  logic [15:0] bubble_cnt;
  logic [1:0]  sat_bubble;

  int pass_cnt  = 0;
  int total_cnt = 0;

  id_ex_stage_if #(.XLEN(32)) id_if ();
  id_ex_stage_if #(.XLEN(32)) sat_if ();

  id_ex_stage #(.XLEN(32), .CNT_W(16)) u_dut (
    .clk(clk), .n_rst(n_rst), .pipe(id_if),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_wr_id(mem_wr_id), .mem_wr_data(mem_wr_data),
    .flush(flush), .hold(hold), .id_stall(id_stall), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) u_sat (
    .clk(clk), .n_rst(n_rst), .pipe(sat_if),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_wr_id(mem_wr_id), .mem_wr_data(mem_wr_data),
    .flush(flush), .hold(hold), .id_stall(sat_stall), .bubble_cnt(sat_bubble)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic wr, input logic ld);
    id_if.id_valid    = v;
    id_if.id_pc       = pc;
    id_if.id_imm      = pc + 32'h1000;
    id_if.id_alu_op   = pc[5:2];
    id_if.id_rs1_id   = rs1;
    id_if.id_rs2_id   = rs2;
    id_if.id_use_rs1  = u1;
    id_if.id_use_rs2  = u2;
    id_if.id_rd_id    = rd;
    id_if.id_rd_wr_en = wr;
    id_if.id_is_load  = ld;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    set_id(1'b1, 32'hdeadbeef, 5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1);
    sat_if.id_valid = 1'b0; sat_if.id_pc = '0; sat_if.id_imm = '0; sat_if.id_alu_op = '0;
    sat_if.id_rs1_id = '0; sat_if.id_rs2_id = '0; sat_if.id_use_rs1 = 1'b0;
    sat_if.id_use_rs2 = 1'b0; sat_if.id_rd_id = '0; sat_if.id_rd_wr_en = 1'b0;
    sat_if.id_is_load = 1'b0;
    rs1_data = 32'h1111_2222; rs2_data = 32'h3333_4444; ex_result = 32'hcafe_f00d;
    mem_wr_en = 1'b1; mem_wr_id = 5'd3; mem_wr_data = 32'h5555_6666;
    flush = 1'b0; hold = 1'b0;
    #3;
    total_cnt++; if (id_stall !== 1'b0) $display("FAIL reset_stall_hold0: got %b want 0", id_stall); else pass_cnt++;
    tick();
    total_cnt++; if (id_if.ex_valid !== 1'b0) $display("FAIL reset_ex_valid: got %b want 0", id_if.ex_valid); else pass_cnt++;
    total_cnt++; if (id_if.ex_pc !== 32'h0) $display("FAIL reset_ex_pc: got %h want 0", id_if.ex_pc); else pass_cnt++;
    total_cnt++; if (id_if.ex_imm !== 32'h0) $display("FAIL reset_ex_imm: got %h want 0", id_if.ex_imm); else pass_cnt++;
    total_cnt++; if ({id_if.ex_alu_op, id_if.ex_rd_id, id_if.ex_rd_wr_en, id_if.ex_is_load} !== 11'h0)
      $display("FAIL reset_ex_ctrl: got %h want 0", {id_if.ex_alu_op, id_if.ex_rd_id, id_if.ex_rd_wr_en, id_if.ex_is_load}); else pass_cnt++;
    total_cnt++; if ({id_if.ex_rs1_val, id_if.ex_rs2_val} !== 64'h0)
      $display("FAIL reset_ex_ops: got %h want 0", {id_if.ex_rs1_val, id_if.ex_rs2_val}); else pass_cnt++;
    total_cnt++; if (bubble_cnt !== 16'h0) $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt); else pass_cnt++;
    hold = 1'b1;
    #1;
    total_cnt++; if (id_stall !== 1'b1) $display("FAIL reset_stall_hold1: got %b want 1", id_stall); else pass_cnt++;
    hold = 1'b0; mem_wr_en = 1'b0; mem_wr_id = '0; mem_wr_data = '0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic test_ex_bypass();
    set_id(1'b1, 32'h40, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    total_cnt++; if (id_if.ex_valid !== 1'b1 || id_if.ex_rd_id !== 5'd5)
      $display("FAIL exbyp_capture: got valid=%b rd=%0d want 1/5", id_if.ex_valid, id_if.ex_rd_id); else pass_cnt++;
    set_id(1'b1, 32'h44, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    rs1_data = 32'd3; rs2_data = 32'd3; ex_result = 32'd7;
    #1;
    total_cnt++; if (id_stall !== 1'b0) $display("FAIL exbyp_stall: got %b want 0", id_stall); else pass_cnt++;
    tick();
    total_cnt++; if (id_if.ex_rs1_val !== 32'd7 || id_if.ex_rs2_val !== 32'd7)
      $display("FAIL exbyp_operands: got %h/%h want 7/7", id_if.ex_rs1_val, id_if.ex_rs2_val); else pass_cnt++;
    total_cnt++; if (id_if.ex_pc !== 32'h44 || id_if.ex_imm !== 32'h1044 || id_if.ex_alu_op !== 4'h1 || id_if.ex_rd_id !== 5'd6)
      $display("FAIL exbyp_fields: got pc=%h imm=%h op=%h rd=%0d want 44/1044/1/6",
               id_if.ex_pc, id_if.ex_imm, id_if.ex_alu_op, id_if.ex_rd_id); else pass_cnt++;
  endtask

  task automatic test_mem_bypass();
    set_id(1'b1, 32'h48, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 32'h4c, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    rs1_data = 32'd3; rs2_data = 32'd3; ex_result = 32'd7;
    mem_wr_en = 1'b1; mem_wr_id = 5'd5; mem_wr_data = 32'd9;
    tick();
    total_cnt++; if (id_if.ex_rs1_val !== 32'd7 || id_if.ex_rs2_val !== 32'd7)
      $display("FAIL membyp_ex_priority: got %h/%h want 7/7", id_if.ex_rs1_val, id_if.ex_rs2_val); else pass_cnt++;
    set_id(1'b1, 32'h50, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    total_cnt++; if (id_if.ex_rs1_val !== 32'd9 || id_if.ex_rs2_val !== 32'd9)
      $display("FAIL membyp_mem_only: got %h/%h want 9/9", id_if.ex_rs1_val, id_if.ex_rs2_val); else pass_cnt++;
    set_id(1'b1, 32'h54, 5'd0, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    mem_wr_id = 5'd0; rs1_data = 32'h1234;
    tick();
    total_cnt++; if (id_if.ex_rs1_val !== 32'd0 || id_if.ex_rs2_val !== 32'd3)
      $display("FAIL membyp_x0_and_rf: got %h/%h want 0/3", id_if.ex_rs1_val, id_if.ex_rs2_val); else pass_cnt++;
    mem_wr_en = 1'b0;
  endtask

  task automatic test_load_use();
    set_id(1'b1, 32'h58, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    rs1_data = 32'h100;
    #1;
    total_cnt++; if (id_stall !== 1'b0) $display("FAIL lu_no_stall_before: got %b want 0", id_stall); else pass_cnt++;
    tick();
    total_cnt++; if (id_if.ex_is_load !== 1'b1) $display("FAIL lu_load_in_ex: got %b want 1", id_if.ex_is_load); else pass_cnt++;
    set_id(1'b1, 32'h5c, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    rs1_data = 32'hdead; rs2_data = 32'h11; ex_result = 32'h77;
    #1;
    total_cnt++; if (id_stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", id_stall); else pass_cnt++;
    tick();
    total_cnt++; if ({id_if.ex_valid, id_if.ex_rd_wr_en, id_if.ex_is_load} !== 3'b000)
      $display("FAIL lu_bubble: got %b want 000", {id_if.ex_valid, id_if.ex_rd_wr_en, id_if.ex_is_load}); else pass_cnt++;
    total_cnt++; if (bubble_cnt !== 16'd1) $display("FAIL lu_bubble_cnt: got %0d want 1", bubble_cnt); else pass_cnt++;
    total_cnt++; if (id_stall !== 1'b0) $display("FAIL lu_stall_released: got %b want 0", id_stall); else pass_cnt++;
    mem_wr_en = 1'b1; mem_wr_id = 5'd5; mem_wr_data = 32'h55;
    tick();
    total_cnt++; if (id_if.ex_rs1_val !== 32'h55 || id_if.ex_rs2_val !== 32'h11)
      $display("FAIL lu_mem_forward: got %h/%h want 55/11", id_if.ex_rs1_val, id_if.ex_rs2_val); else pass_cnt++;
    total_cnt++; if (id_if.ex_valid !== 1'b1 || id_if.ex_rd_id !== 5'd6 || bubble_cnt !== 16'd1)
      $display("FAIL lu_after: got valid=%b rd=%0d cnt=%0d want 1/6/1", id_if.ex_valid, id_if.ex_rd_id, bubble_cnt); else pass_cnt++;
    mem_wr_en = 1'b0;
  endtask

  task automatic test_flush();
    set_id(1'b1, 32'h60, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 32'h64, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    total_cnt++; if (id_stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", id_stall); else pass_cnt++;
    tick();
    total_cnt++; if ({id_if.ex_valid, id_if.ex_rd_wr_en, id_if.ex_is_load} !== 3'b000)
      $display("FAIL flush_bubble: got %b want 000", {id_if.ex_valid, id_if.ex_rd_wr_en, id_if.ex_is_load}); else pass_cnt++;
    total_cnt++; if (bubble_cnt !== 16'd1) $display("FAIL flush_bubble_cnt: got %0d want 1", bubble_cnt); else pass_cnt++;
    flush = 1'b0;
  endtask

  task automatic test_hold();
    set_id(1'b1, 32'h70, 5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    rs1_data = 32'ha;
    tick();
    set_id(1'b1, 32'h74, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    rs1_data = 32'hbb;
    hold = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (id_stall !== 1'b1) $display("FAIL hold_stall_%0d: got %b want 1", i, id_stall); else pass_cnt++;
      tick();
      total_cnt++; if (id_if.ex_valid !== 1'b1 || id_if.ex_pc !== 32'h70 || id_if.ex_rs1_val !== 32'ha || id_if.ex_is_load !== 1'b1)
        $display("FAIL hold_frozen_%0d: got valid=%b pc=%h rs1=%h load=%b want 1/70/a/1",
                 i, id_if.ex_valid, id_if.ex_pc, id_if.ex_rs1_val, id_if.ex_is_load); else pass_cnt++;
      total_cnt++; if (bubble_cnt !== 16'd1) $display("FAIL hold_cnt_%0d: got %0d want 1", i, bubble_cnt); else pass_cnt++;
    end
    hold = 1'b0; flush = 1'b0;
    #1;
    total_cnt++; if (id_stall !== 1'b1) $display("FAIL hold_release_lu_stall: got %b want 1", id_stall); else pass_cnt++;
    tick();
    total_cnt++; if (id_if.ex_valid !== 1'b0 || bubble_cnt !== 16'd2)
      $display("FAIL hold_release_bubble: got valid=%b cnt=%0d want 0/2", id_if.ex_valid, bubble_cnt); else pass_cnt++;
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 5; i++) begin
      sat_if.id_valid = 1'b1; sat_if.id_rs1_id = 5'd2; sat_if.id_use_rs1 = 1'b1;
      sat_if.id_rd_id = 5'd5; sat_if.id_rd_wr_en = 1'b1; sat_if.id_is_load = 1'b1;
      tick();
      sat_if.id_rs1_id = 5'd5; sat_if.id_rd_id = 5'd6; sat_if.id_is_load = 1'b0;
      tick();
      total_cnt++; if (sat_bubble !== ((i < 3) ? 2'(i) : 2'd3))
        $display("FAIL sat_cnt_%0d: got %0d want %0d", i, sat_bubble, (i < 3) ? i : 3); else pass_cnt++;
    end
    sat_if.id_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 32'h80, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 32'h84, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    total_cnt++; if (id_stall !== 1'b1) $display("FAIL rst_mid_pre_stall: got %b want 1", id_stall); else pass_cnt++;
    n_rst = 1'b0;
    #1;
    total_cnt++; if (id_stall !== 1'b0 || id_if.ex_valid !== 1'b0 || bubble_cnt !== 16'd0 || id_if.ex_pc !== 32'h0)
      $display("FAIL rst_mid_clear: got stall=%b valid=%b cnt=%0d pc=%h want 0/0/0/0",
               id_stall, id_if.ex_valid, bubble_cnt, id_if.ex_pc); else pass_cnt++;
    n_rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ex_bypass();
    test_mem_bypass();
    test_load_use();
    test_flush();
    test_hold();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
